// File: rtl/vs_ram_arbiter_pkg.sv
// Shared memory-port types for the VerySimpleCPU RAM path: master ids and the request bundle.
package vs_mem_pkg;

    localparam int SIZE   = 14;
    localparam int DATA_W = 32;

    typedef enum logic {
        M_CPU  = 1'b0,
        M_HOST = 1'b1
    } master_id_t;

    typedef struct packed {
        logic              we;
        logic [SIZE-1:0]   addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/vs_ram_arbiter_rr.sv
// Two-way round-robin grant with last_grant register and a consecutive-lock counter.
// With lock_i tied low the counter stays at zero and arbitration is pure round-robin.
module vs_rr_arb2 #(
    parameter int LOCK_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o
);
    import vs_mem_pkg::*;

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    master_id_t       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_lock;
    logic             hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= M_HOST;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    // A nonzero count means the previous grant was a locked grant to last_q.
    always_comb begin
        owner_lock = (last_q == M_HOST) ? lock_i[1] : lock_i[0];
        hold       = (cnt_q != '0) && (cnt_q < CNT_W'(LOCK_MAX)) && owner_lock;
        gnt_o      = 2'b00;
        if (!rst) begin
            if (req_i == 2'b11) begin
                if (hold)
                    gnt_o = (last_q == M_HOST) ? 2'b10 : 2'b01;
                else
                    gnt_o = (last_q == M_HOST) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        cnt_d  = '0;
        if (gnt_o[0])
            last_d = M_CPU;
        else if (gnt_o[1])
            last_d = M_HOST;
        // Reaching LOCK_MAX always restarts the count, forcing one fair arbitration.
        if ((cnt_q != CNT_W'(LOCK_MAX)) && ((gnt_o & lock_i) != 2'b00))
            cnt_d = (last_d == last_q) ? cnt_q + 1'b1 : CNT_W'(1);
    end

endmodule

// File: rtl/vs_ram_arbiter.sv
// Arbitrates the CPU (m0) and host loader (m1) onto the single-port RAM and routes read data back.
// Optional macro VS_RAM_ARB_LOCK_EN adds m0_lock/m1_lock for locked back-to-back ownership.
module vs_ram_arbiter #(
    parameter int SIZE     = vs_mem_pkg::SIZE,
    parameter int DATA_W   = vs_mem_pkg::DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [SIZE-1:0]   m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [SIZE-1:0]   m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
`ifdef VS_RAM_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic              wrEn,
    output logic [SIZE-1:0]   addr_toRAM,
    output logic [DATA_W-1:0] data_toRAM,
    input  logic [DATA_W-1:0] data_fromRAM
);
    import vs_mem_pkg::*;

    logic [1:0] gnt;
    logic [1:0] lock;
    logic       rv_pend_q, rv_pend_d;
    master_id_t rv_id_q, rv_id_d;

`ifdef VS_RAM_ARB_LOCK_EN
    assign lock = {m1_lock, m0_lock};
`else
    assign lock = 2'b00;
`endif

    vs_rr_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  ({m1_req, m0_req}),
        .lock_i (lock),
        .gnt_o  (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Idle cycles drive zeros so the RAM never sees X on its pins.
    always_comb begin
        wrEn       = 1'b0;
        addr_toRAM = '0;
        data_toRAM = '0;
        if (gnt[0]) begin
            wrEn       = m0_we;
            addr_toRAM = m0_addr;
            data_toRAM = m0_wdata;
        end else if (gnt[1]) begin
            wrEn       = m1_we;
            addr_toRAM = m1_addr;
            data_toRAM = m1_wdata;
        end
    end

    always_comb begin
        rv_pend_d = (gnt[0] && !m0_we) || (gnt[1] && !m1_we);
        rv_id_d   = gnt[1] ? M_HOST : M_CPU;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv_pend_q <= 1'b0;
            rv_id_q   <= M_CPU;
        end else begin
            rv_pend_q <= rv_pend_d;
            rv_id_q   <= rv_id_d;
        end
    end

    // Gating with rst drops a read whose data would land during reset.
    assign m0_rvalid = rv_pend_q && !rst && (rv_id_q == M_CPU);
    assign m1_rvalid = rv_pend_q && !rst && (rv_id_q == M_HOST);
    assign m0_rdata  = m0_rvalid ? data_fromRAM : '0;
    assign m1_rdata  = m1_rvalid ? data_fromRAM : '0;

endmodule

// File: tb/tb_vs_ram_arbiter.sv
// Bench for vs_ram_arbiter: directed scenarios plus a randomized phase against a transaction-level model.
module tb_vs_ram_arbiter;

    localparam int LMAX = 4;

    logic        clk;
    logic        rst;
    logic        r0, w0, r1, w1;
    logic [13:0] a0, a1;
    logic [31:0] d0, d1;
    logic        lk0, lk1;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        wrEn;
    logic [13:0] addr_toRAM;
    logic [31:0] data_toRAM;
    logic [31:0] data_fromRAM;

    logic        pl_en;
    logic [13:0] pl_addr;
    logic [31:0] pl_data;
    bit   [31:0] ram    [0:16383];
    bit   [31:0] shadow [0:16383];

    int          tests;
    int          fails;
    int          m_last;
    int          lcnt;
    int          cur_win;
    bit          cur_we;
    bit          cur_lk;
    bit   [13:0] cur_a;
    bit   [31:0] cur_d;
    bit          m_pend;
    int          m_pid;
    bit   [31:0] m_pdata;
    bit          g0, g1;

    vs_ram_arbiter #(
        .SIZE     (14),
        .DATA_W   (32),
        .LOCK_MAX (LMAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (r0),
        .m0_we        (w0),
        .m0_addr      (a0),
        .m0_wdata     (d0),
        .m0_gnt       (m0_gnt),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req       (r1),
        .m1_we        (w1),
        .m1_addr      (a1),
        .m1_wdata     (d1),
        .m1_gnt       (m1_gnt),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
`ifdef VS_RAM_ARB_LOCK_EN
        .m0_lock      (lk0),
        .m1_lock      (lk1),
`endif
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM),
        .data_fromRAM (data_fromRAM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first single-port RAM with a registered read port.
    always @(posedge clk) begin
        data_fromRAM <= ram[addr_toRAM];
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (wrEn)
            ram[addr_toRAM] <= data_toRAM;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected behaviour for the current inputs, derived from the arbitration rules.
    task automatic evalc();
        bit e_rv0, e_rv1;
        #1;
        cur_win = -1;
        cur_we  = 1'b0;
        cur_a   = '0;
        cur_d   = '0;
        cur_lk  = 1'b0;
        if (!rst) begin
            if (r0 && r1) begin
                cur_win = (m_last == 0) ? 1 : 0;
`ifdef VS_RAM_ARB_LOCK_EN
                if (lcnt > 0 && lcnt < LMAX && ((m_last == 0) ? lk0 : lk1))
                    cur_win = m_last;
`endif
            end else if (r0) begin
                cur_win = 0;
            end else if (r1) begin
                cur_win = 1;
            end
        end
        if (cur_win == 0) begin
            cur_we = w0; cur_a = a0; cur_d = d0; cur_lk = lk0;
        end else if (cur_win == 1) begin
            cur_we = w1; cur_a = a1; cur_d = d1; cur_lk = lk1;
        end
        e_rv0 = !rst && m_pend && (m_pid == 0);
        e_rv1 = !rst && m_pend && (m_pid == 1);
        chk("m0_gnt", 32'(m0_gnt), 32'(cur_win == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(cur_win == 1));
        chk("wrEn", 32'(wrEn), 32'(cur_we));
        chk("addr_toRAM", 32'(addr_toRAM), 32'(cur_a));
        chk("data_toRAM", data_toRAM, cur_d);
        chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
        chk("m0_rdata", m0_rdata, e_rv0 ? m_pdata : 32'h0);
        chk("m1_rdata", m1_rdata, e_rv1 ? m_pdata : 32'h0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (rst) begin
            m_last = 1;
            m_pend = 1'b0;
            lcnt   = 0;
        end else begin
            m_pend = 1'b0;
            if (cur_win >= 0) begin
                if (cur_we) begin
                    shadow[cur_a] = cur_d;
                end else begin
                    m_pend  = 1'b1;
                    m_pid   = cur_win;
                    m_pdata = shadow[cur_a];
                end
            end
            if (lcnt == LMAX)
                lcnt = 0;
            else if (cur_win >= 0 && cur_lk)
                lcnt = (cur_win == m_last) ? lcnt + 1 : 1;
            else
                lcnt = 0;
            if (cur_win >= 0)
                m_last = cur_win;
        end
    endtask

    function automatic logic [13:0] pick_addr();
        return ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
    endfunction

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1;
        r0 = 1'b1; w0 = 1'b0; a0 = 14'h001; d0 = '0;
        r1 = 1'b1; w1 = 1'b0; a1 = 14'h005; d1 = '0;
        lk0 = 1'b0; lk1 = 1'b0;
        m_last = 1; lcnt = 0; m_pend = 1'b0; m_pid = 0; m_pdata = '0;
        pl_en = 1'b1; pl_addr = 14'h005; pl_data = 32'hDEADBEEF;
        shadow[5] = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        pl_en = 1'b0;

        // Reset held with both masters requesting
        repeat (2) begin
            evalc();
            chk("rst_no_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
            chk("rst_wren", 32'(wrEn), 32'h0);
            adv();
        end
        rst = 1'b0;
        evalc();
        chk("first_grant_m0", 32'(m0_gnt), 32'h1);
        adv();

        // Uncontended m1 read of 0x005
        r0 = 1'b0;
        evalc();
        chk("rd_m1_gnt", 32'(m1_gnt), 32'h1);
        adv();
        r1 = 1'b0;
        evalc();
        chk("rd_m1_rvalid", 32'(m1_rvalid), 32'h1);
        chk("rd_m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("rd_m0_rvalid_quiet", 32'(m0_rvalid), 32'h0);
        adv();

        // Continuous contention alternates starting with m0
        r0 = 1'b1; a0 = 14'h007; r1 = 1'b1; a1 = 14'h009;
        for (int i = 0; i < 6; i++) begin
            evalc();
            chk("cont_m0", 32'(m0_gnt), 32'(i % 2 == 0));
            chk("cont_m1", 32'(m1_gnt), 32'(i % 2 == 1));
            adv();
        end
        r0 = 1'b0; r1 = 1'b0;
        evalc();
        adv();

        // Write to top address then read it back
        r0 = 1'b1; w0 = 1'b1; a0 = 14'h3FFF; d0 = 32'h12345678;
        evalc();
        chk("wr_wren", 32'(wrEn), 32'h1);
        adv();
        w0 = 1'b0;
        evalc();
        adv();
        r0 = 1'b0;
        evalc();
        chk("rd_after_wr_valid", 32'(m0_rvalid), 32'h1);
        chk("rd_after_wr_data", m0_rdata, 32'h12345678);
        adv();

        // Reset lands on the cycle the read data would return
        r0 = 1'b1; a0 = 14'h005;
        evalc();
        adv();
        r0 = 1'b0; rst = 1'b1;
        evalc();
        chk("rst_mid_rvalid", 32'(m0_rvalid), 32'h0);
        adv();
        rst = 1'b0;
        evalc();
        chk("post_rst_rvalid", 32'(m0_rvalid), 32'h0);
        adv();
        r0 = 1'b1; r1 = 1'b1;
        evalc();
        chk("post_rst_m0_first", 32'(m0_gnt), 32'h1);
        adv();
        r0 = 1'b0;
        evalc();
        adv();
        r1 = 1'b0; r0 = 1'b1;
        evalc();
        adv();

`ifdef VS_RAM_ARB_LOCK_EN
        // m1 locked against a competing m0: four m1 grants, one m0, then m1 again
        r0 = 1'b1; r1 = 1'b1; lk1 = 1'b1; a0 = 14'h010; a1 = 14'h011;
        for (int i = 0; i < 6; i++) begin
            evalc();
            chk("lock_m1", 32'(m1_gnt), 32'(i != 4));
            chk("lock_m0", 32'(m0_gnt), 32'(i == 4));
            adv();
            if (i == 4) r0 = 1'b0;
        end
        r1 = 1'b0; lk1 = 1'b0;
        evalc();
        adv();
`endif

        // Randomized traffic; a request is held unchanged until granted
        r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            evalc();
            g0 = (cur_win == 0);
            g1 = (cur_win == 1);
            adv();
            rst = ($urandom_range(0, 63) == 0);
            if (!r0 || g0) begin
                r0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
                a0 = pick_addr(); d0 = $urandom;
            end
            if (!r1 || g1) begin
                r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
                a1 = pick_addr(); d1 = $urandom;
            end
`ifdef VS_RAM_ARB_LOCK_EN
            lk0 = ($urandom_range(0, 2) == 0);
            lk1 = ($urandom_range(0, 2) == 0);
`endif
        end
        rst = 1'b0; r0 = 1'b0; r1 = 1'b0;
        evalc();
        adv();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
